capi_primem_rdstrm: RTL and testbench

// - Streaming read engine upstream/downstream of the low-priority read port of the priority dual-read memory.
// - Accepts a {start addr, count, tag} command; issues count sequential reads on the low-priority port.
// - Collects the in-order returned data into a registered output stream with tag and last flag.
// - Caps outstanding reads so the memory's low-priority return path never backs up beyond one holding stage.

---
 rtl/capi_primem_rdstrm.sv | 213 +++++++++++++++++++++
 tb/tb_capi_primem_rdstrm.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capi_primem_rdstrm.sv
`timescale 1ns/1ps
// capi_primem_rdstrm
//
// Purpose: streaming read engine that sits on the low-priority read port of
// the priority dual-read memory. A {start address, count, tag} command is
// turned into `count` sequential reads. The in-order returns are collected
// into one registered output stage that carries the tag and a last flag.
// At most max_outst reads are in flight at once. A read counts as in flight
// from its issue until its data is delivered on o_*. This limit keeps the
// memory's low-priority return path from backing up.
//
// Optional feature: define CAPI_PRIMEM_RDSTRM_PERF_EN to build the two
// saturating performance counters. Without the macro both perf outputs are
// tied to zero and no counter flops exist.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   cmd_v/cmd_r                 command handshake
//   cmd_addr/cmd_cnt/cmd_tag    command fields (cnt 0 = 2**cnt_width reads)
//   o_rd_v/o_rd_r               read request handshake to the memory
//   o_rd_a/o_rd_aux             read address and {tag, last}
//   i_rd_v/i_rd_r               read return handshake from the memory
//   i_rd_d/i_rd_aux             return data and {tag, last}
//   o_v/o_r                     output beat handshake
//   o_d/o_tag/o_last            output beat payload
//   o_idle                      no command active and nothing in flight
//   o_perf_busy/o_perf_stl      busy-cycle and output-stall counters
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A source holds valid and its payload stable until the transfer
// happens. Ready may change freely.

module capi_primem_rdstrm #(
   parameter int width      = 32,
   parameter int addr_width = 8,
   parameter int cnt_width  = 8,
   parameter int tag_width  = 4,
   parameter int max_outst  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_v,
   output logic                   cmd_r,
   input  logic [addr_width-1:0]  cmd_addr,
   input  logic [cnt_width-1:0]   cmd_cnt,
   input  logic [tag_width-1:0]   cmd_tag,
   output logic                   o_rd_v,
   input  logic                   o_rd_r,
   output logic [addr_width-1:0]  o_rd_a,
   output logic [tag_width:0]     o_rd_aux,
   input  logic                   i_rd_v,
   output logic                   i_rd_r,
   input  logic [width-1:0]       i_rd_d,
   input  logic [tag_width:0]     i_rd_aux,
   output logic                   o_v,
   input  logic                   o_r,
   output logic [width-1:0]       o_d,
   output logic [tag_width-1:0]   o_tag,
   output logic                   o_last,
   output logic                   o_idle,
   output logic [31:0]            o_perf_busy,
   output logic [31:0]            o_perf_stl
);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_ISSUE = 1'b1;

   localparam logic [3:0] OUTST_MAX = 4'(max_outst);

   logic                  state_q, state_d;
   logic [addr_width-1:0] addr_q, addr_d;
   logic [cnt_width-1:0]  rem_q, rem_d;
   logic [tag_width-1:0]  tag_q, tag_d;
   logic [3:0]            outst_q, outst_d;
   // Comes up one clock after reset release. It holds cmd_r, i_rd_r and
   // o_idle low until then.
   logic                  alive_q, alive_d;
   logic                  o_v_q, o_v_d;
   logic [width-1:0]      o_d_q, o_d_d;
   logic [tag_width-1:0]  o_tag_q, o_tag_d;
   logic                  o_last_q, o_last_d;

   logic cmd_fire, rd_fire, ret_fire, out_fire, rd_last;

   // A remaining count of 0 after latching means 2**cnt_width reads.
   // Decrementing through the wrap gives the right total.
   assign rd_last  = (rem_q == cnt_width'(1));

   assign cmd_r    = alive_q & (state_q == ST_IDLE);
   assign o_rd_v   = (state_q == ST_ISSUE) & (outst_q < OUTST_MAX);
   assign o_rd_a   = addr_q;
   assign o_rd_aux = {tag_q, rd_last};
   assign i_rd_r   = alive_q & (~o_v_q | o_r);
   assign o_v      = o_v_q;
   assign o_d      = o_d_q;
   assign o_tag    = o_tag_q;
   assign o_last   = o_last_q;
   assign o_idle   = alive_q & (state_q == ST_IDLE) & (outst_q == 4'd0);

   assign cmd_fire = cmd_v & cmd_r;
   assign rd_fire  = o_rd_v & o_rd_r;
   assign ret_fire = i_rd_v & i_rd_r;
   assign out_fire = o_v_q & o_r;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      tag_d   = tag_q;
      alive_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               state_d = ST_ISSUE;
               addr_d  = cmd_addr;
               rem_d   = cmd_cnt;
               tag_d   = cmd_tag;
            end
         end
         default: begin
            if (rd_fire) begin
               addr_d = addr_q + addr_width'(1);
               rem_d  = rem_q - cnt_width'(1);
               // Returns come back in order, so the next command may start
               // while earlier data is still in flight.
               if (rd_last) state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      outst_d = outst_q;
      case ({rd_fire, out_fire})
         2'b10:   outst_d = outst_q + 4'd1;
         2'b01:   outst_d = outst_q - 4'd1;
         default: outst_d = outst_q;
      endcase
   end

   always_comb begin
      o_v_d    = o_v_q;
      o_d_d    = o_d_q;
      o_tag_d  = o_tag_q;
      o_last_d = o_last_q;
      if (ret_fire) begin
         o_v_d    = 1'b1;
         o_d_d    = i_rd_d;
         o_tag_d  = i_rd_aux[tag_width:1];
         o_last_d = i_rd_aux[0];
      end else if (out_fire) begin
         o_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         tag_q    <= '0;
         outst_q  <= '0;
         alive_q  <= 1'b0;
         o_v_q    <= 1'b0;
         o_d_q    <= '0;
         o_tag_q  <= '0;
         o_last_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         tag_q    <= tag_d;
         outst_q  <= outst_d;
         alive_q  <= alive_d;
         o_v_q    <= o_v_d;
         o_d_q    <= o_d_d;
         o_tag_q  <= o_tag_d;
         o_last_q <= o_last_d;
      end
   end

`ifdef CAPI_PRIMEM_RDSTRM_PERF_EN
   logic [31:0] perf_busy_q, perf_busy_d;
   logic [31:0] perf_stl_q, perf_stl_d;

   // Both counters stick at all-ones instead of wrapping.
   always_comb begin
      perf_busy_d = perf_busy_q;
      perf_stl_d  = perf_stl_q;
      if (!o_idle && (perf_busy_q != 32'hFFFF_FFFF))
         perf_busy_d = perf_busy_q + 32'd1;
      if (o_v_q && !o_r && (perf_stl_q != 32'hFFFF_FFFF))
         perf_stl_d = perf_stl_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_busy_q <= '0;
         perf_stl_q  <= '0;
      end else begin
         perf_busy_q <= perf_busy_d;
         perf_stl_q  <= perf_stl_d;
      end
   end

   assign o_perf_busy = perf_busy_q;
   assign o_perf_stl  = perf_stl_q;
`else
   assign o_perf_busy = 32'd0;
   assign o_perf_stl  = 32'd0;
`endif

endmodule

// File: tb/tb_capi_primem_rdstrm.sv
`timescale 1ns/1ps
// Bench for capi_primem_rdstrm. A memory responder returns reads in order
// with random delay. The model turns each accepted command into its list of
// expected read addresses and output beats, and it tracks in-flight reads
// from the observed handshakes.

module tb_capi_primem_rdstrm;

   localparam int MAX_OUTST = 4;

`ifdef CAPI_PRIMEM_RDSTRM_PERF_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        cmd_v, cmd_r;
   logic [7:0]  cmd_addr, cmd_cnt;
   logic [3:0]  cmd_tag;
   logic        o_rd_v, o_rd_r;
   logic [7:0]  o_rd_a;
   logic [4:0]  o_rd_aux;
   logic        i_rd_v, i_rd_r;
   logic [31:0] i_rd_d;
   logic [4:0]  i_rd_aux;
   logic        o_v, o_r;
   logic [31:0] o_d;
   logic [3:0]  o_tag;
   logic        o_last, o_idle;
   logic [31:0] o_perf_busy, o_perf_stl;

   capi_primem_rdstrm #(
      .width(32), .addr_width(8), .cnt_width(8), .tag_width(4), .max_outst(MAX_OUTST)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_v(cmd_v), .cmd_r(cmd_r), .cmd_addr(cmd_addr), .cmd_cnt(cmd_cnt), .cmd_tag(cmd_tag),
      .o_rd_v(o_rd_v), .o_rd_r(o_rd_r), .o_rd_a(o_rd_a), .o_rd_aux(o_rd_aux),
      .i_rd_v(i_rd_v), .i_rd_r(i_rd_r), .i_rd_d(i_rd_d), .i_rd_aux(i_rd_aux),
      .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_tag(o_tag), .o_last(o_last),
      .o_idle(o_idle), .o_perf_busy(o_perf_busy), .o_perf_stl(o_perf_stl)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- model state ----------------
   logic [31:0] mem [256];
   logic [19:0] cmd_q[$];      // {addr, cnt, tag}
   logic [12:0] exp_rd_q[$];   // {addr, tag, last}
   logic [36:0] exp_q[$];      // {data, tag, last}
   logic [36:0] ret_q[$];      // memory return pipe {data, aux}
   int          rd_acc, ret_acc, beats;
   logic [31:0] busy_m, stl_m;
   int          last_iss_cyc = -100;
   int          last_gap = -1;
   bit          ret_hold;
   bit          env_en = 1'b0;
   int          or_pct = 100, rdr_pct = 100, ret_pct = 100;

   int n_vec = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- memory responder + scoreboard ----------------
   initial begin : env
      int          outst_m;
      bit          idle_m;
      logic [19:0] c;
      logic [7:0]  a;
      logic [36:0] e;
      int          n;
      forever begin
         @(negedge clk);
         if (env_en) begin
            outst_m = rd_acc - beats;
            idle_m  = (exp_rd_q.size() == 0) && (outst_m == 0);
            chk("cmd_r",      cmd_r,  exp_rd_q.size() == 0);
            chk("o_rd_v",     o_rd_v, (exp_rd_q.size() != 0) && (outst_m < MAX_OUTST));
            chk("o_v",        o_v,    ret_acc != beats);
            chk("o_idle",     o_idle, idle_m);
            chk("outst_cap",  outst_m <= MAX_OUTST, 1'b1);
            chk("perf_busy",  o_perf_busy, PERF_ON ? busy_m : 32'd0);
            chk("perf_stl",   o_perf_stl,  PERF_ON ? stl_m  : 32'd0);

            // drive this cycle's inputs
            o_r    = ($urandom_range(0, 99) < or_pct);
            o_rd_r = ($urandom_range(0, 99) < rdr_pct);
            if (!ret_hold && ret_q.size() != 0 && $urandom_range(0, 99) < ret_pct) ret_hold = 1'b1;
            if (ret_hold) begin
               i_rd_v = 1'b1;
               {i_rd_d, i_rd_aux} = ret_q[0];
            end else begin
               i_rd_v   = 1'b0;
               i_rd_d   = $urandom;
               i_rd_aux = 5'($urandom);
            end
            if (cmd_q.size() != 0) begin
               cmd_v = 1'b1;
               {cmd_addr, cmd_cnt, cmd_tag} = cmd_q[0];
            end else begin
               cmd_v = 1'b0;
            end

            #1;
            chk("i_rd_r", i_rd_r, !o_v || o_r);
            if (o_rd_v) begin
               chk("rd_expected", exp_rd_q.size() != 0, 1'b1);
               if (exp_rd_q.size() != 0) begin
                  chk("o_rd_a",   o_rd_a,   exp_rd_q[0][12:5]);
                  chk("o_rd_aux", o_rd_aux, exp_rd_q[0][4:0]);
               end
               if (o_rd_r) begin
                  if (exp_rd_q.size() != 0) void'(exp_rd_q.pop_front());
                  ret_q.push_back({mem[o_rd_a], o_rd_aux});
                  rd_acc++;
                  if (o_rd_aux[0]) last_iss_cyc = cyc;
               end
            end
            if (o_v && o_r) begin
               beats++;
               chk("beat_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("o_d",    o_d,    e[36:5]);
                  chk("o_tag",  o_tag,  e[4:1]);
                  chk("o_last", o_last, e[0]);
               end
            end
            if (i_rd_v && i_rd_r) begin
               void'(ret_q.pop_front());
               ret_acc++;
               ret_hold = 1'b0;
            end
            if (cmd_v && cmd_r) begin
               c = cmd_q.pop_front();
               last_gap = cyc - last_iss_cyc;
               n = (c[11:4] == 8'd0) ? 256 : int'(c[11:4]);
               for (int i = 0; i < n; i++) begin
                  a = c[19:12] + 8'(i);
                  exp_rd_q.push_back({a, c[3:0], 1'(i == n - 1)});
                  exp_q.push_back({mem[a], c[3:0], 1'(i == n - 1)});
               end
            end
            if (!idle_m) busy_m = busy_m + 32'd1;
            if (o_v && !o_r) stl_m = stl_m + 32'd1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic zero_inputs();
      cmd_v = 1'b0; cmd_addr = '0; cmd_cnt = '0; cmd_tag = '0;
      o_rd_r = 1'b0; i_rd_v = 1'b0; i_rd_d = '0; i_rd_aux = '0; o_r = 1'b0;
   endtask

   task automatic check_in_reset();
      chk("rst_o_rd_v", o_rd_v, 1'b0);
      chk("rst_o_v",    o_v,    1'b0);
      chk("rst_o_d",    o_d,    32'd0);
      chk("rst_o_tag",  o_tag,  4'd0);
      chk("rst_o_last", o_last, 1'b0);
      chk("rst_cmd_r",  cmd_r,  1'b0);
      chk("rst_i_rd_r", i_rd_r, 1'b0);
      chk("rst_o_idle", o_idle, 1'b0);
      chk("rst_busy",   o_perf_busy, 32'd0);
      chk("rst_stl",    o_perf_stl,  32'd0);
   endtask

   task automatic release_reset();
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      chk("rel_cmd_r_pre",  cmd_r,  1'b0);
      chk("rel_o_idle_pre", o_idle, 1'b0);
      chk("rel_i_rd_r_pre", i_rd_r, 1'b0);
      @(negedge clk); #1;
      chk("rel_cmd_r",  cmd_r,  1'b1);
      chk("rel_o_idle", o_idle, 1'b1);
      chk("rel_i_rd_r", i_rd_r, 1'b1);
      chk("rel_o_rd_v", o_rd_v, 1'b0);
      chk("rel_busy",   o_perf_busy, PERF_ON ? 32'd1 : 32'd0);
      cmd_q.delete(); exp_rd_q.delete(); exp_q.delete(); ret_q.delete();
      rd_acc = 0; ret_acc = 0; beats = 0;
      busy_m = 32'd1; stl_m = 32'd0; ret_hold = 1'b0;
      #1;
      env_en = 1'b1;
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while ((cmd_q.size() != 0 || exp_q.size() != 0 || exp_rd_q.size() != 0) && n < limit) begin
         @(negedge clk); #2;
         n++;
      end
      chk("drain_in_time", (cmd_q.size() == 0) && (exp_q.size() == 0) && (exp_rd_q.size() == 0), 1'b1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      int base_b, base_r, n;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      reset = 1'b0;
      zero_inputs();
      @(negedge clk); #1;
      check_in_reset();
      release_reset();

      // basic command, full-rate
      base_b = beats;
      cmd_q.push_back({8'h10, 8'd4, 4'd3});
      wait_drain(200);
      chk("t1_beats", beats - base_b, 4);
      @(negedge clk); #2;
      chk("t1_idle", o_idle, 1'b1);

      // address wrap FE,FF,00,01
      base_b = beats;
      cmd_q.push_back({8'hFE, 8'd4, 4'd5});
      wait_drain(200);
      chk("t2_beats", beats - base_b, 4);

      // output blocked: issue stops at max_outst
      or_pct = 0;
      base_b = beats; base_r = rd_acc;
      cmd_q.push_back({8'h20, 8'd10, 4'd6});
      repeat (30) @(negedge clk);
      #2;
      chk("t3_reads_capped", rd_acc - base_r, 4);
      chk("t3_o_rd_v_low",   o_rd_v, 1'b0);
      or_pct = 100;
      wait_drain(200);
      chk("t3_reads_total", rd_acc - base_r, 10);
      chk("t3_beats",       beats - base_b, 10);

      // count 0 means 256 reads
      base_b = beats;
      cmd_q.push_back({8'h80, 8'd0, 4'd9});
      wait_drain(1500);
      chk("t4_beats", beats - base_b, 256);

      // back-to-back commands
      base_b = beats;
      cmd_q.push_back({8'h30, 8'd2, 4'd1});
      cmd_q.push_back({8'h40, 8'd3, 4'd2});
      wait_drain(200);
      chk("t5_gap",   last_gap, 1);
      chk("t5_beats", beats - base_b, 5);

      // randomized traffic
      base_b = 0;
      for (int k = 0; k < 12; k++) begin
         or_pct  = $urandom_range(30, 100);
         rdr_pct = $urandom_range(30, 100);
         ret_pct = $urandom_range(30, 100);
         n = $urandom_range(1, 24);
         base_b += n;
         cmd_q.push_back({8'($urandom), 8'(n), 4'($urandom)});
      end
      base_r = beats;
      wait_drain(5000);
      chk("t6_beats", beats - base_r, base_b);

      // reset in the middle of a command with three reads in flight
      or_pct = 0; rdr_pct = 100; ret_pct = 100;
      cmd_q.push_back({8'hC0, 8'd10, 4'hA});
      n = 0;
      while ((rd_acc - beats) != 3 && n < 50) begin
         @(negedge clk); #2;
         n++;
      end
      chk("t7_outst3", rd_acc - beats, 3);
      env_en = 1'b0;
      @(negedge clk); #2;
      reset = 1'b0;
      zero_inputs();
      #1;
      check_in_reset();
      @(negedge clk); #1;
      check_in_reset();
      release_reset();

      // recovery
      or_pct = 100;
      base_b = beats;
      cmd_q.push_back({8'h55, 8'd3, 4'd7});
      wait_drain(200);
      chk("t8_beats", beats - base_b, 3);
      @(negedge clk); #2;
      chk("t8_idle", o_idle, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
